// File: rtl/proc_pkg.sv
// Shared opcode/funct constants and enumerations for the multi-cycle RV32I OP/OP-IMM core.
package proc_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_FETCH, ST_WAIT, ST_EXEC, ST_WB, ST_HALT
    } state_t;

    // Maps funct3 plus the "alternate" bit (SUB/SRA) onto an ALU operation.
    function automatic alu_op_t alu_sel(input logic [2:0] f3, input logic alt);
        unique case (f3)
            F3_ADD_SUB: alu_sel = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     alu_sel = ALU_SLL;
            F3_SLT:     alu_sel = ALU_SLT;
            F3_SLTU:    alu_sel = ALU_SLTU;
            F3_XOR:     alu_sel = ALU_XOR;
            F3_SR:      alu_sel = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      alu_sel = ALU_OR;
            default:    alu_sel = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational integer ALU; shifts use the low log2(XLEN) bits of i_b.
module core_alu
    import proc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  alu_op_t         i_op,
    output logic [XLEN-1:0] o_result
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] w_shamt;
    assign w_shamt = i_b[SHW-1:0];

    always_comb begin
        o_result = '0;
        unique case (i_op)
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_SLL:  o_result = i_a << w_shamt;
            ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SRL:  o_result = i_a >> w_shamt;
            ALU_SRA:  o_result = $signed(i_a) >>> w_shamt;
            ALU_OR:   o_result = i_a | i_b;
            ALU_AND:  o_result = i_a & i_b;
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_processor.sv
// Multi-cycle RV32I OP/OP-IMM core: FETCH -> WAIT -> EXEC -> WB, halting on illegal instructions.
// state    | meaning
// FETCH    | request instruction at pc, hold until accepted
// WAIT     | wait for instruction word, latch into instr
// EXEC     | decode, read operands, compute result (or halt)
// WB       | write rd, advance pc, count retirement
// HALT     | stopped on illegal instruction until reset
module multicycle_processor
    import proc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rdata,
    output logic            halted,
    output logic [31:0]     retire_count,
    output logic [XLEN-1:0] dbg_pc
);

    localparam int RIW = $clog2(NREG);

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_result;
    logic [31:0]     r_instr;
    logic [31:0]     r_retire;
    logic            r_halted;
    logic [XLEN-1:0] r_regs [NREG];

    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic [RIW-1:0]  w_rs1_idx;
    logic [RIW-1:0]  w_rs2_idx;
    logic [RIW-1:0]  w_rd_idx;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_imm;
    logic            w_shift_ok;
    logic            w_legal;
    logic            w_use_imm;
    alu_op_t         w_alu_op;
    logic [XLEN-1:0] w_alu_result;

    function automatic logic reg_ok(input logic [4:0] idx);
        reg_ok = (32'(idx) < NREG);
    endfunction

    assign w_opc     = r_instr[6:0];
    assign w_rd      = r_instr[11:7];
    assign w_f3      = r_instr[14:12];
    assign w_rs1     = r_instr[19:15];
    assign w_rs2     = r_instr[24:20];
    assign w_f7      = r_instr[31:25];
    assign w_rs1_idx = w_rs1[RIW-1:0];
    assign w_rs2_idx = w_rs2[RIW-1:0];
    assign w_rd_idx  = w_rd[RIW-1:0];
    assign w_imm     = {{(XLEN-12){r_instr[31]}}, r_instr[31:20]};
    assign w_rs1_val = (w_rs1_idx == '0) ? '0 : r_regs[w_rs1_idx];
    assign w_rs2_val = (w_rs2_idx == '0) ? '0 : r_regs[w_rs2_idx];

    // Immediate shifts: upper shamt field must be zero except the SRAI marker; bit 25 is
    // shamt[5] and only meaningful on a 64-bit datapath.
    assign w_shift_ok = ((r_instr[31:26] == 6'b000000) ||
                         (w_f3 == F3_SR && r_instr[31:26] == 6'b010000)) &&
                        (XLEN == 64 || !r_instr[25]);

    always_comb begin
        w_legal   = 1'b0;
        w_use_imm = 1'b0;
        w_alu_op  = ALU_ADD;
        if (w_opc == OPC_OP) begin
            w_alu_op = alu_sel(w_f3, w_f7[5]);
            w_legal  = ((w_f7 == F7_BASE) ||
                        (w_f7 == F7_ALT && (w_f3 == F3_ADD_SUB || w_f3 == F3_SR))) &&
                       reg_ok(w_rs1) && reg_ok(w_rs2) && reg_ok(w_rd);
        end else if (w_opc == OPC_OP_IMM) begin
            w_use_imm = 1'b1;
            w_alu_op  = alu_sel(w_f3, (w_f3 == F3_SR) && r_instr[30]);
            w_legal   = ((w_f3 != F3_SLL && w_f3 != F3_SR) || w_shift_ok) &&
                        reg_ok(w_rs1) && reg_ok(w_rd);
        end
    end

    core_alu #(.XLEN(XLEN)) u_alu (
        .i_a      (w_rs1_val),
        .i_b      (w_use_imm ? w_imm : w_rs2_val),
        .i_op     (w_alu_op),
        .o_result (w_alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_FETCH;
            r_pc     <= RESET_PC;
            r_instr  <= '0;
            r_result <= '0;
            r_retire <= '0;
            r_halted <= 1'b0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            unique case (r_state)
                ST_FETCH: if (imem_req_ready) r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_instr <= imem_rdata;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_legal) begin
                        r_result <= w_alu_result;
                        r_state  <= ST_WB;
                    end else begin
                        r_halted <= 1'b1;
                        r_state  <= ST_HALT;
                    end
                end
                ST_WB: begin
                    if (w_rd_idx != '0) r_regs[w_rd_idx] <= r_result;
                    r_pc     <= r_pc + XLEN'(4);
                    r_retire <= r_retire + 32'd1;
                    r_state  <= ST_FETCH;
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_HALT;
            endcase
        end
    end

    // Gated by rst_n so the request drops immediately while reset is held, yet rises in
    // the very first cycle after release.
    assign imem_req_valid = rst_n && (r_state == ST_FETCH);
    assign imem_addr      = r_pc;
    assign dbg_pc         = r_pc;
    assign halted         = r_halted;
    assign retire_count   = r_retire;

endmodule

// File: tb/tb_multicycle_processor.sv
// Self-checking bench: directed plus randomized OP/OP-IMM programs against an ISA-level model.
module tb_multicycle_processor;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [6:0]  OP     = 7'b0110011;
    localparam logic [6:0]  OPI    = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic        halted;
    logic [31:0] retire_count;
    logic [31:0] dbg_pc;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [31:0] m_retire;

    multicycle_processor #(.XLEN(32), .NREG(32), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .halted         (halted),
        .retire_count   (retire_count),
        .dbg_pc         (dbg_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        enc_r = {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), OP};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input int rs1,
                                          input logic [2:0] f3, input int rd);
        enc_i = {imm, 5'(rs1), f3, 5'(rd), OPI};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc     = RST_PC;
        m_retire = '0;
    endtask

    // ISA-level semantics of one instruction; returns legality and destination.
    task automatic model_step(input logic [31:0] ins, output bit legal, output int rd);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a, b, r;
        logic [4:0]  sh;
        opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        rd  = int'(ins[11:7]);
        a   = m_regs[ins[19:15]];
        b   = '0;
        r   = '0;
        legal = 1'b1;
        if (opc == OP) begin
            b = m_regs[ins[24:20]];
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        end else if (opc == OPI) begin
            b = {{20{ins[31]}}, ins[31:20]};
            if (f3 == 3'd1) legal = (f7 == 7'h00);
            if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
        end else begin
            legal = 1'b0;
        end
        sh = b[4:0];
        case (f3)
            3'd0: r = (opc == OP && f7[5]) ? a - b : a + b;
            3'd1: r = a << sh;
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: if (f7[5]) r = $signed(a) >>> sh; else r = a >> sh;
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        if (legal) begin
            if (rd != 0) m_regs[rd] = r;
            m_pc     = m_pc + 32'd4;
            m_retire = m_retire + 32'd1;
        end
    endtask

    // Drives one full fetch/response handshake from a negedge in FETCH and checks the outcome.
    task automatic run_instr(input logic [31:0] ins, input int rdly, input int sdly);
        bit legal;
        int rd;
        logic [31:0] pc0, ret0;
        pc0  = m_pc;
        ret0 = m_retire;
        check("fetch_valid", {31'd0, imem_req_valid}, 32'd1);
        check("fetch_addr", imem_addr, m_pc);
        for (int k = 0; k < rdly; k++) begin
            imem_req_ready = 1'b0;
            @(negedge clk);
            check("hold_valid", {31'd0, imem_req_valid}, 32'd1);
            check("hold_addr", imem_addr, pc0);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        check("wait_valid", {31'd0, imem_req_valid}, 32'd0);
        for (int k = 0; k < sdly; k++) @(negedge clk);
        imem_rsp_valid = 1'b1;
        imem_rdata     = ins;
        @(negedge clk);
        // A stray response during EXEC must not disturb the latched instruction.
        imem_rsp_valid = 1'($urandom_range(0, 1));
        imem_rdata     = $urandom;
        model_step(ins, legal, rd);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        if (legal) begin
            check("wb_valid", {31'd0, imem_req_valid}, 32'd0);
            @(negedge clk);
            check("next_valid", {31'd0, imem_req_valid}, 32'd1);
            check("pc", dbg_pc, m_pc);
            check("retire", retire_count, m_retire);
            check("rd_value", dut.r_regs[rd], m_regs[rd]);
            check("x0", dut.r_regs[0], 32'd0);
        end else begin
            check("halted", {31'd0, halted}, 32'd1);
            check("halt_pc", dbg_pc, pc0);
            check("halt_retire", retire_count, ret0);
            for (int k = 0; k < 4; k++) begin
                imem_req_ready = 1'b1;
                @(negedge clk);
                check("halt_noreq", {31'd0, imem_req_valid}, 32'd0);
            end
            imem_req_ready = 1'b0;
            check("halt_pc_stay", dbg_pc, pc0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        check("rst_valid", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_retire", retire_count, 32'd0);
        check("rst_pc", dbg_pc, RST_PC);
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        int k, rd, rs1, rs2;
        logic [11:0] imm;
        logic [4:0]  sh;
        k   = $urandom_range(0, 18);
        rd  = $urandom_range(0, 31);
        rs1 = $urandom_range(0, 31);
        rs2 = $urandom_range(0, 31);
        imm = 12'($urandom);
        sh  = 5'($urandom);
        case (k)
            0:  rand_instr = enc_r(7'h00, rs2, rs1, 3'd0, rd);
            1:  rand_instr = enc_r(7'h20, rs2, rs1, 3'd0, rd);
            2:  rand_instr = enc_r(7'h00, rs2, rs1, 3'd1, rd);
            3:  rand_instr = enc_r(7'h00, rs2, rs1, 3'd2, rd);
            4:  rand_instr = enc_r(7'h00, rs2, rs1, 3'd3, rd);
            5:  rand_instr = enc_r(7'h00, rs2, rs1, 3'd4, rd);
            6:  rand_instr = enc_r(7'h00, rs2, rs1, 3'd5, rd);
            7:  rand_instr = enc_r(7'h20, rs2, rs1, 3'd5, rd);
            8:  rand_instr = enc_r(7'h00, rs2, rs1, 3'd6, rd);
            9:  rand_instr = enc_r(7'h00, rs2, rs1, 3'd7, rd);
            10: rand_instr = enc_i(imm, rs1, 3'd0, rd);
            11: rand_instr = enc_i(imm, rs1, 3'd2, rd);
            12: rand_instr = enc_i(imm, rs1, 3'd3, rd);
            13: rand_instr = enc_i(imm, rs1, 3'd4, rd);
            14: rand_instr = enc_i(imm, rs1, 3'd6, rd);
            15: rand_instr = enc_i(imm, rs1, 3'd7, rd);
            16: rand_instr = enc_i({7'h00, sh}, rs1, 3'd1, rd);
            17: rand_instr = enc_i({7'h00, sh}, rs1, 3'd5, rd);
            default: rand_instr = enc_i({7'h20, sh}, rs1, 3'd5, rd);
        endcase
    endfunction

    initial begin
        imem_rdata = '0;
        do_reset();

        run_instr(enc_i(12'd5, 0, 3'd0, 1), 0, 0);
        check("first_x1", dut.r_regs[1], 32'd5);
        check("first_pc", dbg_pc, 32'h104);
        check("first_retire", retire_count, 32'd1);

        run_instr(enc_i(12'hFFF, 0, 3'd0, 1), 0, 0);
        run_instr(enc_r(7'h00, 1, 0, 3'd3, 2), 0, 0);
        run_instr(enc_r(7'h00, 0, 1, 3'd2, 3), 0, 0);
        run_instr(enc_i({7'h20, 5'd4}, 1, 3'd5, 4), 0, 0);
        run_instr(enc_i({7'h00, 5'd4}, 1, 3'd5, 6), 0, 0);
        check("neg_x1", dut.r_regs[1], 32'hFFFF_FFFF);
        check("sltu_x2", dut.r_regs[2], 32'd1);
        check("slt_x3", dut.r_regs[3], 32'd1);
        check("srai_x4", dut.r_regs[4], 32'hFFFF_FFFF);
        check("srli_x6", dut.r_regs[6], 32'h0FFF_FFFF);

        run_instr(enc_i(12'd7, 0, 3'd0, 0), 1, 0);
        run_instr(enc_r(7'h00, 0, 0, 3'd0, 5), 0, 1);
        check("x0_add_x5", dut.r_regs[5], 32'd0);

        run_instr(enc_i(12'h123, 0, 3'd0, 7), 3, 2);
        check("stall_x7", dut.r_regs[7], 32'h123);

        for (int n = 0; n < 150; n++)
            run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 2));
        for (int i = 0; i < 32; i++) check("regfile_scan", dut.r_regs[i], m_regs[i]);

        // Reset while a fetch is outstanding; the late response lands in FETCH.
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        imem_rsp_valid = 1'b1;
        imem_rdata     = enc_i(12'd99, 0, 3'd0, 1);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("midrst_addr", imem_addr, RST_PC);
        check("midrst_retire", retire_count, 32'd0);
        check("midrst_x1", dut.r_regs[1], 32'd0);
        check("midrst_x9", dut.r_regs[9], 32'd0);
        run_instr(enc_r(7'h00, 1, 1, 3'd0, 2), 0, 0);
        run_instr(enc_i(12'd3, 2, 3'd0, 2), 0, 0);

        run_instr(enc_i({7'h01, 5'd3}, 2, 3'd1, 8), 0, 0);
        do_reset();
        run_instr(enc_i(12'd1, 0, 3'd0, 1), 0, 0);
        run_instr(enc_i(12'd2, 1, 3'd0, 1), 0, 0);
        run_instr({12'd0, 5'd1, 3'd2, 5'd3, 7'b0000011}, 1, 1);
        rst_n = 1'b0;
        #1;
        check("rst_clears_halt", {31'd0, halted}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
